// File: rtl/mantissa_normalizer_pkg.sv
// Shared floating-point definitions: default operand widths and normalizer FSM encodings.
package mantissa_normalizer_pkg;

  localparam int unsigned NormW  = 16;  // mantissa width
  localparam int unsigned NormSw = 4;   // shift-count width, 2**NormSw == NormW
  localparam int unsigned NormEw = 5;   // exponent width

  // Four fixed halving stages (8, 4, 2, 1) cover a 16-bit mantissa.
  typedef enum logic [2:0] {
    StIdle,
    St8,
    St4,
    St2,
    St1,
    StDone
  } norm_state_e;

endpackage

// File: rtl/mantissa_normalizer_if.sv
// Operand/result handshake bundle for the mantissa normalizer.
interface mantissa_normalizer_if
  import mantissa_normalizer_pkg::*;
#(
  parameter int unsigned W  = NormW,
  parameter int unsigned SW = NormSw,
  parameter int unsigned EW = NormEw
) ();

  logic          in_valid;
  logic          in_ready;
  logic [W:1]    a;
  logic [EW:1]   exp_in;
  logic          out_valid;
  logic          out_ready;
  logic [W:1]    out;
  logic [SW:1]   shift;
  logic [EW:1]   exp_out;
  logic          zero;
  logic          underflow;

  // Producer/consumer side driving operands and accepting results.
  modport master (
    output in_valid, a, exp_in, out_ready,
    input  in_ready, out_valid, out, shift, exp_out, zero, underflow
  );

  // Normalizer side.
  modport slave (
    input  in_valid, a, exp_in, out_ready,
    output in_ready, out_valid, out, shift, exp_out, zero, underflow
  );

endinterface

// File: rtl/mantissa_normalizer_norm_stage.sv
// One conditional normalization step: shift left by k when the top k bits are all zero.
module mantissa_normalizer_norm_stage #(
  parameter int unsigned W  = 16,
  parameter int unsigned SW = 4
) (
  input  logic [W:1]  value_i,
  input  logic [SW:1] k_i,
  output logic [W:1]  value_o,
  output logic        shifted_o
);

  logic [W:1] top_mask;

  // Mask selects the top k bits; shift only when they are all clear.
  always_comb begin
    top_mask  = ~({W{1'b1}} >> k_i);
    shifted_o = ((value_i & top_mask) == '0);
    value_o   = shifted_o ? (value_i << k_i) : value_i;
  end

endmodule

// File: rtl/mantissa_normalizer.sv
// Multi-cycle leading-zero normalizer: four binary-search stages, then a held result.
module mantissa_normalizer
  import mantissa_normalizer_pkg::*;
#(
  parameter int unsigned W  = NormW,
  parameter int unsigned SW = NormSw,
  parameter int unsigned EW = NormEw
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mantissa_normalizer_if.slave bus
);

  norm_state_e state_q;
  logic [W:1]  work_q;
  logic [SW:1] cnt_q;
  logic [EW:1] exp_q;
  logic [W:1]  out_q;
  logic [SW:1] shift_q;
  logic [EW:1] exp_out_q;
  logic        zero_q;
  logic        underflow_q;
  logic        in_ready_q;
  logic        out_valid_q;

  logic [SW:1] stage_k;
  logic [W:1]  stage_value;
  logic        stage_shifted;
  logic [SW:1] cnt_d;
  logic        fin_zero;
  logic        fin_under;
  logic [EW:1] fin_exp;

  // Stage width follows the state; idle/done feed k=0 so the stage is a pass-through.
  always_comb begin
    case (state_q)
      St8:     stage_k = SW'(8);
      St4:     stage_k = SW'(4);
      St2:     stage_k = SW'(2);
      St1:     stage_k = SW'(1);
      default: stage_k = '0;
    endcase
  end

  mantissa_normalizer_norm_stage #(
    .W  (W),
    .SW (SW)
  ) u_norm_stage (
    .value_i   (work_q),
    .k_i       (stage_k),
    .value_o   (stage_value),
    .shifted_o (stage_shifted)
  );

  // Running shift count and the final result fields computed during the last stage.
  always_comb begin
    cnt_d     = cnt_q + (stage_shifted ? stage_k : '0);
    // After all stages a nonzero value always has its MSB set.
    fin_zero  = ~stage_value[W];
    fin_under = !fin_zero && (32'(exp_q) < 32'(cnt_d));
    if (fin_zero || fin_under) begin
      fin_exp = fin_zero ? exp_q : '0;
    end else begin
      fin_exp = exp_q - EW'(cnt_d);
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      work_q      <= '0;
      cnt_q       <= '0;
      exp_q       <= '0;
      out_q       <= '0;
      shift_q     <= '0;
      exp_out_q   <= '0;
      zero_q      <= 1'b0;
      underflow_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid && in_ready_q) begin
            work_q     <= bus.a;
            exp_q      <= bus.exp_in;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= St8;
          end
        end
        St8: begin
          work_q  <= stage_value;
          cnt_q   <= cnt_d;
          state_q <= St4;
        end
        St4: begin
          work_q  <= stage_value;
          cnt_q   <= cnt_d;
          state_q <= St2;
        end
        St2: begin
          work_q  <= stage_value;
          cnt_q   <= cnt_d;
          state_q <= St1;
        end
        St1: begin
          out_q       <= stage_value;
          shift_q     <= fin_zero ? '0 : cnt_d;
          exp_out_q   <= fin_exp;
          zero_q      <= fin_zero;
          underflow_q <= fin_under;
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          // Ready is raised only after the handshake edge, so no same-cycle reissue.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.shift     = shift_q;
  assign bus.exp_out   = exp_out_q;
  assign bus.zero      = zero_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_mantissa_normalizer.sv
// Directed and random-vector bench for mantissa_normalizer.
module tb_mantissa_normalizer;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mantissa_normalizer_if #(.W(16), .SW(4), .EW(5)) bus ();

  mantissa_normalizer #(.W(16), .SW(4), .EW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned chk_cnt  = 0;
  int unsigned pass_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    chk_cnt++;
    if (obs === exp_v) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  function automatic int unsigned lzc16(input logic [16:1] v);
    int unsigned n = 0;
    for (int i = 16; i >= 1; i--) begin
      if (v[i]) break;
      n++;
    end
    return (n == 16) ? 0 : n;
  endfunction

  // Present one operand, then wait for out_valid and check the fixed 4-clock latency.
  task automatic issue(input logic [16:1] a, input logic [5:1] e, input string tag);
    int lat;
    int waits;
    waits = 0;
    while (bus.in_ready !== 1'b1 && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.exp_in    = e;
    @(negedge clk);
    // Garbage with in_valid high while busy must be ignored.
    bus.a      = 16'($urandom);
    bus.exp_in = 5'($urandom);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 10) begin
      if (lat == 1) check({tag, " busy"}, {30'd0, bus.in_ready, bus.out_valid}, 32'd0);
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'd4);
  endtask

  task automatic check_res(input string tag, input logic [16:1] o, input logic [4:1] sh,
                           input logic [5:1] eo, input logic z, input logic u);
    check({tag, " out"}, 32'(bus.out), 32'(o));
    check({tag, " shift"}, 32'(bus.shift), 32'(sh));
    check({tag, " exp_out"}, 32'(bus.exp_out), 32'(eo));
    check({tag, " zero"}, 32'(bus.zero), 32'(z));
    check({tag, " underflow"}, 32'(bus.underflow), 32'(u));
  endtask

  task automatic ack(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, " ack"}, {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [16:1] ra;
    logic [5:1]  re;
    int unsigned sh;
    logic        bad;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.exp_in    = '0;
    rst_n         = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check_res("reset", 16'h0000, 4'd0, 5'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(16'h0001, 5'd20, "lsb");
    check_res("lsb", 16'h8000, 4'd15, 5'd5, 1'b0, 1'b0);
    ack("lsb");

    issue(16'h8000, 5'd3, "msb");
    check_res("msb", 16'h8000, 4'd0, 5'd3, 1'b0, 1'b0);
    ack("msb");

    issue(16'h0000, 5'd7, "zero");
    check_res("zero", 16'h0000, 4'd0, 5'd7, 1'b1, 1'b0);
    ack("zero");

    issue(16'h00F0, 5'd4, "uflow");
    check_res("uflow", 16'hF000, 4'd8, 5'd0, 1'b0, 1'b1);
    ack("uflow");

    issue(16'h00F0, 5'd8, "exp_eq");
    check_res("exp_eq", 16'hF000, 4'd8, 5'd0, 1'b0, 1'b0);
    ack("exp_eq");

    issue(16'h0001, 5'd14, "uflow1");
    check_res("uflow1", 16'h8000, 4'd15, 5'd0, 1'b0, 1'b1);
    ack("uflow1");

    // Result must hold while the consumer stalls.
    issue(16'h0350, 5'd9, "hold");
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out !== 16'hD400 || bus.shift !== 4'd6 || bus.exp_out !== 5'd3 ||
          bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad = 1'b1;
    end
    check("hold stable", 32'(bad), 32'd0);
    check_res("hold", 16'hD400, 4'd6, 5'd3, 1'b0, 1'b0);
    ack("hold");

    // Reset mid-flight in S4 discards the operand.
    bus.in_valid = 1'b1;
    bus.a        = 16'h0001;
    bus.exp_in   = 5'd20;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst in_ready", 32'(bus.in_ready), 32'd1);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check_res("rst", 16'h0000, 4'd0, 5'd0, 1'b0, 1'b0);
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) bad = 1'b1;
    end
    check("rst no emit", 32'(bad), 32'd0);

    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      if (ra == 16'h0000) ra = 16'h0001;
      re = 5'($urandom);
      sh = lzc16(ra);
      issue(ra, re, "rand");
      check("rand msb", 32'(bus.out[16]), 32'd1);
      check("rand restore", 32'(bus.out >> bus.shift), 32'(ra));
      check_res("rand", 16'(ra << sh), 4'(sh), (32'(re) < sh) ? 5'd0 : 5'(32'(re) - sh),
                1'b0, (32'(re) < sh));
      ack("rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mantissa_normalizer.md
MANTISSA_NORMALIZER -- requirements
Module: mantissa_normalizer

Interface
REQ-001 SHALL declare parameter W, default 16: mantissa width, bits numbered [W:1].
REQ-002 SHALL declare parameter SW, default 4: shift-count width, satisfying 2^SW = W.
REQ-003 SHALL declare parameter EW, default 5: exponent width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 in_valid  input  1  A and exp_in are valid.
REQ-007 in_ready  output  1  block can accept an operand.
REQ-008 A  input  [W:1]  unnormalized mantissa.
REQ-009 exp_in  input  [EW:1]  exponent associated with A.
REQ-010 out_valid  output  1  result fields are valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out  output  [W:1]  normalized mantissa.
REQ-013 Shift  output  [SW:1]  left-shift amount applied to A.
REQ-014 exp_out  output  [EW:1]  adjusted exponent.
REQ-015 zero  output  1  A was all-zero.
REQ-016 underflow  output  1  exp_in < Shift; exp_out saturated.

Function
REQ-017 SHALL use an FSM with states IDLE, S8, S4, S2, S1, DONE.
REQ-018 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-019 in_valid&&in_ready at an edge SHALL capture A into a working register, clear the count and move to S8.
REQ-020 Each Sk state SHALL take one cycle: if the top k bits of the working register are 0, shift it left by k (zero-fill) and add k to the count; then advance S8->S4->S2->S1->DONE.
REQ-021 out_valid SHALL rise exactly 4 clocks after the accepting edge, independent of data.
REQ-022 For nonzero A, out[W] SHALL be 1, Shift SHALL equal the leading-zero count of A, and out SHALL equal A << Shift.
REQ-023 For A=0: out=0, Shift=0, zero=1, exp_out=exp_in, underflow=0.
REQ-024 For nonzero A: exp_out = exp_in - Shift; if exp_in < Shift, exp_out=0 and underflow=1.
REQ-025 DONE SHALL hold all outputs stable until out_ready=1, then return to IDLE on that edge.
REQ-026 A new operand SHALL NOT be accepted in the same cycle as the output handshake (minimum 6-cycle issue interval).
REQ-027 in_valid outside IDLE SHALL be ignored; A and exp_in need only be stable at the accepting edge.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE and clear out, Shift, exp_out, zero, underflow and out_valid to 0, with in_ready=1 in the following cycle.
REQ-029 Reset asserted in any state, including S8..S1 or DONE with out_ready=0, SHALL discard the in-flight operand without emitting it.

Structure
REQ-030 State encodings and the default W/SW/EW values SHALL reside in the shared floating-point definitions include file, used by all FP-operation blocks.
REQ-031 The per-state conditional shift SHALL be implemented by one combinational sub-module, norm_stage (inputs: value and k; outputs: shifted value and a did-shift flag), instantiated once and selected by state.
REQ-032 Registered outputs SHALL drive out, Shift, exp_out, zero and underflow.

Verification
REQ-033 A=16'h0001, exp_in=20, out_ready=1 -> out=16'h8000, Shift=15, exp_out=5, out_valid exactly 4 clocks after accept.
REQ-034 A=16'h8000, exp_in=3 -> out=16'h8000, Shift=0, exp_out=3, zero=0, underflow=0.
REQ-035 A=16'h0000, exp_in=7 -> out=0, Shift=0, zero=1, exp_out=7.
REQ-036 A=16'h00F0, exp_in=4 -> out=16'hF000, Shift=8, exp_out=0, underflow=1.
REQ-037 Result for A=16'h0350 held with out_ready=0 for 10 cycles -> outputs (16'hD400, Shift=6) stable, in_ready=0; rst_n=0 in S4 on a second operand -> IDLE next cycle, no out_valid.
REQ-038 Random nonzero A -> logical right shift of out by Shift equals A, and out[16]=1.
